sync_down_counter: RTL and testbench
====================================

# sync_down_counter

Synchronous, loadable down-counter: the count-down counterpart to the team's 4-bit synchronous up counter. It is loaded with a start value, decrements once per enabled clock and flags terminal count. It runs one-shot or in auto-reload mode. It sits beside the up counter as the lab's timer/delay primitive, driving event strobes and delay intervals for downstream FSMs.

## Interface
- WIDTH, 4, counter width in bits (legal range 2–16)
- clk  input  1  rising-edge clock; sole clock domain
- reset  input  1  synchronous, active-high reset; sampled on rising clk edge
- load  input  1  parallel-load strobe
- load_val  input  WIDTH  start/reload value, captured when load=1
- en  input  1  count enable; one decrement per cycle while high in RUN
- auto_reload  input  1  1 = reload from stored value at terminal count; 0 = one-shot
- count  output  WIDTH  current registered count
- zero  output  1  high when count == 0 (decoded from registered count)
- tc_pulse  output  1  registered one-cycle strobe, high in the cycle after a terminal-count event
- busy  output  1  high when the FSM is in RUN

## Operation
- Storage: count register, reload register (WIDTH bits), 1-bit state (IDLE, RUN), tc_pulse flop.
- Priority per edge: reset > load > en.
- Reset: count=0, reload=0, state=IDLE, tc_pulse=0. Resulting outputs: busy=0, zero=1.
- Load (any state): count<=load_val, reload<=load_val, tc_pulse<=0.
  - load_val != 0: next state RUN.
  - load_val == 0: next state IDLE.
- RUN, en=1, count > 1: count<=count-1, tc_pulse<=0.
- RUN, en=1, count == 1 (terminal event): tc_pulse<=1.
  - auto_reload=1: count<=reload, stay in RUN.
  - auto_reload=0: count<=0, state<=IDLE.
- RUN, en=0: count, state and reload hold; tc_pulse<=0.
- IDLE, en=1 or en=0: count holds at 0. No wrap to all-ones, no tc_pulse.
- auto_reload is sampled only at the terminal event. It may change freely at other times.
- The arithmetic is a WIDTH-bit decrement only. No underflow is possible because count is never decremented from 0.

## Timing
- Load latency: count shows load_val in the first cycle after the load edge.
- One-shot delay: after load of N≥1 with en held high, tc_pulse is high in exactly the Nth cycle after the load cycle. In that same cycle count=0, zero=1 and busy=0.
- Auto-reload period: with en held high, tc_pulse repeats every N cycles. Count sequence: N, N-1, …, 1, N, …
- N=1 with auto_reload=1: count stays 1 and tc_pulse is high every enabled cycle.
- Stalls: en gaps stretch the interval by the number of en-low cycles. tc_pulse never fires in a cycle whose preceding edge had en=0.
- load coincident with the terminal event: load wins, tc_pulse=0 and the new value is taken.
- reset mid-count: all state clears on that edge. tc_pulse=0 even if the edge would have been a terminal event.
- tc_pulse width is exactly one cycle, except the N=1 auto-reload case above.
- zero and busy are combinational decodes of registered state. There are no input-to-output combinational paths.

## Test plan
- Reset then idle: reset=1 for 2 cycles, then en=1 for 5 cycles -> count=0, zero=1, busy=0, tc_pulse=0 throughout.
- One-shot: load 4'd5, auto_reload=0, en=1 -> count 5,4,3,2,1,0. tc_pulse high only when count reaches 0, busy falls in the same cycle, and count holds at 0 afterward.
- Auto-reload with stall: load 4'd3, auto_reload=1, en=1 except en=0 for 2 cycles after the first reload -> tc_pulse spaced 3 then 5 cycles. Count sequence 3,2,1,3,3,3,2,1,3.
- Boundary values:
  - load 4'd15 one-shot -> tc_pulse 15 cycles after load.
  - load 4'd0 -> stays IDLE, no tc_pulse.
  - load 4'd1 with auto_reload=1 -> tc_pulse every cycle, count=1.
- Collisions:
  - load 4'd7 on the cycle count==1 -> next count=7, tc_pulse=0.
  - reset on the cycle count==1 -> count=0, tc_pulse=0, busy=0.
  - reset and load together -> reset wins.

Source files
------------

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable down-counter with terminal-count strobe and auto-reload
// Count register, reload register, IDLE/RUN state and a registered terminal-count pulse.
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_pulse_q, tc_pulse_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        tc_pulse_d = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            // RUN always holds a nonzero count, so the decrement never underflows
            if (count_q == ONE) begin
                tc_pulse_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            tc_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            tc_pulse_q <= tc_pulse_d;
        end
    end

    assign count    = count_q;
    assign zero     = (count_q == '0);
    assign tc_pulse = tc_pulse_q;
    assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// tb/tb_sync_down_counter.sv - scoreboard bench for sync_down_counter
// Expected {count, zero, tc_pulse, busy} tuples are queued as stimulus is driven.
module tb_sync_down_counter;

    typedef struct packed {
        logic [3:0] count;
        logic       zero;
        logic       tc;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       en = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] count;
    logic       zero;
    logic       tc_pulse;
    logic       busy;

    exp_t sb[$];
    exp_t x;
    int   n_vec = 0;
    int   n_err = 0;

    sync_down_counter #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .zero        (zero),
        .tc_pulse    (tc_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input int c, input bit tc, input bit b);
        exp_t e;
        e.count = 4'(c);
        e.zero  = (c == 0);
        e.tc    = tc;
        e.busy  = b;
        return e;
    endfunction

    // Drive one cycle of inputs, queue its expected result, and advance past the edge.
    task automatic apply(input bit r, input bit ld, input int lv, input bit e, input bit ar,
                         input exp_t exp_v);
        reset       = r;
        load        = ld;
        load_val    = 4'(lv);
        en          = e;
        auto_reload = ar;
        sb.push_back(exp_v);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 7; i++) begin
            apply(i < 2, 1'b0, 0, i >= 2, 1'b0, ex(0, 0, 0));
            x = sb.pop_front();
            n_vec++;
            if ({count, zero, tc_pulse, busy} !== x) begin
                n_err++;
                $display("FAIL reset step %0d: got cnt=%0d z=%b tc=%b busy=%b, want cnt=%0d z=%b tc=%b busy=%b",
                         i, count, zero, tc_pulse, busy, x.count, x.zero, x.tc, x.busy);
            end
        end
    endtask

    task automatic test_one_shot(input int n);
        for (int k = 0; k <= n + 3; k++) begin
            if (k == 0)
                apply(1'b0, 1'b1, n, 1'b1, 1'b0, ex(n, 0, 1));
            else if (k <= n)
                apply(1'b0, 1'b0, 0, 1'b1, 1'b0, ex(n - k, k == n, k != n));
            else
                apply(1'b0, 1'b0, 0, 1'b1, 1'b0, ex(0, 0, 0));
            x = sb.pop_front();
            n_vec++;
            if ({count, zero, tc_pulse, busy} !== x) begin
                n_err++;
                $display("FAIL one_shot_%0d step %0d: got cnt=%0d z=%b tc=%b busy=%b, want cnt=%0d z=%b tc=%b busy=%b",
                         n, k, count, zero, tc_pulse, busy, x.count, x.zero, x.tc, x.busy);
            end
        end
    endtask

    task automatic test_auto_stall();
        int cs[9];
        bit es[9];
        bit ts[9];
        cs = '{3, 2, 1, 3, 3, 3, 2, 1, 3};
        es = '{0, 1, 1, 1, 0, 0, 1, 1, 1};
        ts = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int k = 0; k < 9; k++) begin
            apply(1'b0, k == 0, (k == 0) ? 3 : 0, es[k], 1'b1, ex(cs[k], ts[k], 1));
            x = sb.pop_front();
            n_vec++;
            if ({count, zero, tc_pulse, busy} !== x) begin
                n_err++;
                $display("FAIL auto_stall step %0d: got cnt=%0d z=%b tc=%b busy=%b, want cnt=%0d z=%b tc=%b busy=%b",
                         k, count, zero, tc_pulse, busy, x.count, x.zero, x.tc, x.busy);
            end
        end
    endtask

    task automatic test_boundary();
        // load 0 stays idle; load 1 with auto-reload pulses every enabled cycle
        for (int k = 0; k < 10; k++) begin
            case (k)
                0:       apply(1'b0, 1'b1, 0, 1'b1, 1'b1, ex(0, 0, 0));
                1, 2, 3: apply(1'b0, 1'b0, 0, 1'b1, 1'b1, ex(0, 0, 0));
                4:       apply(1'b0, 1'b1, 1, 1'b0, 1'b1, ex(1, 0, 1));
                8:       apply(1'b0, 1'b0, 0, 1'b0, 1'b1, ex(1, 0, 1));
                9:       apply(1'b0, 1'b0, 0, 1'b1, 1'b0, ex(0, 1, 0));
                default: apply(1'b0, 1'b0, 0, 1'b1, 1'b1, ex(1, 1, 1));
            endcase
            x = sb.pop_front();
            n_vec++;
            if ({count, zero, tc_pulse, busy} !== x) begin
                n_err++;
                $display("FAIL boundary step %0d: got cnt=%0d z=%b tc=%b busy=%b, want cnt=%0d z=%b tc=%b busy=%b",
                         k, count, zero, tc_pulse, busy, x.count, x.zero, x.tc, x.busy);
            end
        end
    endtask

    task automatic test_collisions();
        for (int k = 0; k < 11; k++) begin
            case (k)
                0:  apply(1'b0, 1'b1, 2, 1'b0, 1'b0, ex(2, 0, 1));
                1:  apply(1'b0, 1'b0, 0, 1'b1, 1'b0, ex(1, 0, 1));
                2:  apply(1'b0, 1'b1, 7, 1'b1, 1'b0, ex(7, 0, 1));
                3:  apply(1'b0, 1'b0, 0, 1'b1, 1'b0, ex(6, 0, 1));
                4:  apply(1'b0, 1'b1, 2, 1'b1, 1'b1, ex(2, 0, 1));
                5:  apply(1'b0, 1'b0, 0, 1'b1, 1'b1, ex(1, 0, 1));
                6:  apply(1'b1, 1'b0, 0, 1'b1, 1'b1, ex(0, 0, 0));
                7:  apply(1'b0, 1'b0, 0, 1'b1, 1'b1, ex(0, 0, 0));
                8:  apply(1'b0, 1'b1, 4, 1'b0, 1'b0, ex(4, 0, 1));
                9:  apply(1'b1, 1'b1, 9, 1'b1, 1'b0, ex(0, 0, 0));
                default: apply(1'b0, 1'b0, 0, 1'b1, 1'b0, ex(0, 0, 0));
            endcase
            x = sb.pop_front();
            n_vec++;
            if ({count, zero, tc_pulse, busy} !== x) begin
                n_err++;
                $display("FAIL collisions step %0d: got cnt=%0d z=%b tc=%b busy=%b, want cnt=%0d z=%b tc=%b busy=%b",
                         k, count, zero, tc_pulse, busy, x.count, x.zero, x.tc, x.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        // reload mid-count, then a one-shot ending while auto_reload toggles beforehand
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: apply(1'b0, 1'b1, 4, 1'b1, 1'b1, ex(4, 0, 1));
                1: apply(1'b0, 1'b0, 0, 1'b1, 1'b1, ex(3, 0, 1));
                2: apply(1'b0, 1'b1, 2, 1'b1, 1'b1, ex(2, 0, 1));
                3: apply(1'b0, 1'b0, 0, 1'b1, 1'b1, ex(1, 0, 1));
                4: apply(1'b0, 1'b0, 0, 1'b1, 1'b0, ex(0, 1, 0));
                default: apply(1'b0, 1'b0, 0, 1'b1, 1'b1, ex(0, 0, 0));
            endcase
            x = sb.pop_front();
            n_vec++;
            if ({count, zero, tc_pulse, busy} !== x) begin
                n_err++;
                $display("FAIL back_to_back step %0d: got cnt=%0d z=%b tc=%b busy=%b, want cnt=%0d z=%b tc=%b busy=%b",
                         k, count, zero, tc_pulse, busy, x.count, x.zero, x.tc, x.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot(5);
        test_auto_stall();
        test_one_shot(15);
        test_boundary();
        test_collisions();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
